labs_search_unit: RTL



---
 rtl/labs_pkg.sv | 27 ++
 rtl/labs_autocorr.sv | 25 ++
 rtl/labs_search_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/labs_pkg.sv
// labs_pkg: shared types and helpers for the LABS search workers.
// State encoding, popcount and the worst-case sidelobe energy bound.
package labs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ACC,
    CMP,
    DONE
  } state_t;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  // Energy of the all-equal sequence: sum of (N-k)^2 for k = 1..N-1
  function automatic longint max_energy(input int n);
    return longint'(n - 1) * longint'(n) * longint'(2 * n - 1) / 6;
  endfunction

endpackage

// File: rtl/labs_autocorr.sv
// labs_autocorr: aperiodic autocorrelation C_k of one sequence at lag k.
// Bit value 1 maps to +1, 0 maps to -1.
module labs_autocorr
  import labs_pkg::*;
#(
  parameter int SEQ_WIDTH = 8,
  parameter int KW        = $clog2(SEQ_WIDTH),
  parameter int CW        = KW + 1
) (
  input  logic [SEQ_WIDTH-1:0] seq,
  input  logic [KW-1:0]        k,
  output logic signed [CW-1:0] c
);

  logic [SEQ_WIDTH-1:0] diff;
  int                   ones;

  // Pair bit i with bit i+k; the shifted mask keeps only N-k pairs
  always_comb begin
    diff = (seq ^ (seq >> k)) & ({SEQ_WIDTH{1'b1}} >> k);
    ones = popcount(32'(diff));
    c    = CW'(SEQ_WIDTH - int'(k) - 2 * ones);
  end

endmodule

// File: rtl/labs_search_unit.sv
// labs_search_unit: one LABS search worker; serial sidelobe energy
// over a strided slice of the half search space, tracking the best.
module labs_search_unit
  import labs_pkg::*;
#(
  parameter int SEQ_WIDTH      = 8,
  parameter int E_WIDTH        = 16,
  parameter int PARALLEL_UNITS = 4,
  parameter int UNIT_ID        = 0
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 i_rst,
  output logic [SEQ_WIDTH-1:0] o_seq,
  output logic [E_WIDTH-1:0]   o_e,
  output logic                 o_done
);

  localparam int KW   = $clog2(SEQ_WIDTH);
  localparam int CW   = KW + 1;
  localparam int SQW  = 2 * KW;
  localparam int SW   = ((E_WIDTH > SQW) ? E_WIDTH : SQW) + 1;
  localparam int HALF = 2 ** (SEQ_WIDTH - 1);
  localparam int CNT  = (PARALLEL_UNITS > HALF) ? 1 : HALF / PARALLEL_UNITS;

  localparam logic [SEQ_WIDTH-1:0] FIRST = SEQ_WIDTH'(UNIT_ID);
  localparam logic [SEQ_WIDTH-1:0] LAST  =
    SEQ_WIDTH'(UNIT_ID + (CNT - 1) * PARALLEL_UNITS);
  localparam logic [SEQ_WIDTH-1:0] STEP  = SEQ_WIDTH'(PARALLEL_UNITS);
  localparam logic [KW-1:0]        KLAST = KW'(SEQ_WIDTH - 1);
  localparam logic [SW-1:0]        ESAT  = SW'({E_WIDTH{1'b1}});

  if (max_energy(SEQ_WIDTH) > longint'(ESAT)) begin : g_ewidth_chk
    $error("E_WIDTH cannot hold the worst-case energy");
  end

  state_t                state;
  logic [SEQ_WIDTH-1:0]  cand;
  logic [SEQ_WIDTH-1:0]  work;
  logic [KW-1:0]         k;
  logic [E_WIDTH-1:0]    acc;
  logic signed [CW-1:0]  c;
  logic [KW-1:0]         mag;
  logic [SQW-1:0]        sq;
  logic [SW-1:0]         sum;
  logic [E_WIDTH-1:0]    acc_next;

  labs_autocorr #(
    .SEQ_WIDTH(SEQ_WIDTH),
    .KW       (KW),
    .CW       (CW)
  ) u_autocorr (
    .seq(work),
    .k  (k),
    .c  (c)
  );

  // |C_k| <= N-1 fits KW bits, so the square fits 2*KW bits
  always_comb begin
    mag      = KW'(c[CW-1] ? -c : c);
    sq       = SQW'(mag) * SQW'(mag);
    sum      = SW'(acc) + SW'(sq);
    acc_next = (sum > ESAT) ? {E_WIDTH{1'b1}} : sum[E_WIDTH-1:0];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state  <= IDLE;
      cand   <= FIRST;
      work   <= '0;
      k      <= '0;
      acc    <= '0;
      o_seq  <= '0;
      o_e    <= '1;
      o_done <= 1'b0;
    end else if (i_rst) begin
      state  <= IDLE;
      cand   <= FIRST;
      work   <= '0;
      k      <= '0;
      acc    <= '0;
      o_seq  <= '0;
      o_e    <= '1;
      o_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: state <= LOAD;
        LOAD: begin
          work  <= cand;
          acc   <= '0;
          k     <= KW'(1);
          state <= ACC;
        end
        ACC: begin
          acc <= acc_next;
          k   <= k + KW'(1);
          if (k == KLAST) state <= CMP;
        end
        CMP: begin
          if (acc < o_e) begin
            o_seq <= cand;
            o_e   <= acc;
          end
          if (cand == LAST) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            cand  <= cand + STEP;
            state <= LOAD;
          end
        end
        DONE: o_done <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
